// File: rtl/mem_access_unit.sv
// Load/store unit between a simple request port and a big-endian byte-addressed memory.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to reject misaligned halfword/word requests.
module mem_access_unit #(
   parameter int unsigned MEM_DEPTH = 250000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] w_addr_32,
   output logic [31:0] w_data_in_32,
   input  logic [31:0] w_data_out_32,
   output logic        rw,
   output logic        en
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

   state_t      state_q, state_d;
   logic        store_q, store_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [15:0] wdata_q, wdata_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        en_q, en_d;
   logic        rw_q, rw_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        out_of_range;
   logic        misalign;
   logic        bad_req;

   // The memory delivers the addressed byte in [31:24], so narrow loads take the top bits.
   function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] size,
                                               input logic uns);
      logic [31:0] r;
      case (size)
         SZ_BYTE: r = uns ? {24'd0, rd[31:24]} : {{24{rd[31]}}, rd[31:24]};
         SZ_HALF: r = uns ? {16'd0, rd[31:16]} : {{16{rd[31]}}, rd[31:16]};
         default: r = rd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_store(input logic [31:0] rd, input logic [15:0] wd,
                                               input logic [1:0] size);
      return (size == SZ_BYTE) ? {wd[7:0], rd[23:0]} : {wd, rd[15:0]};
   endfunction

   assign out_of_range = ({1'b0, req_addr} + 33'd3) > 33'(MEM_DEPTH);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif
   assign bad_req = (req_size == SZ_RSVD) || out_of_range || misalign;

   always_comb begin
      state_d      = state_q;
      store_d      = store_q;
      size_d       = size_q;
      uns_d        = uns_q;
      wdata_d      = wdata_q;
      addr_d       = addr_q;
      mem_wdata_d  = mem_wdata_q;
      en_d         = en_q;
      rw_d         = rw_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               store_d = req_store;
               size_d  = req_size;
               uns_d   = req_unsigned;
               wdata_d = req_wdata[15:0];
               addr_d  = req_addr;
               if (bad_req) begin
                  state_d      = ERR;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_store && (req_size == SZ_WORD)) begin
                  state_d     = WRITE;
                  en_d        = 1'b1;
                  rw_d        = 1'b0;
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d = READ;
                  en_d    = 1'b1;
                  rw_d    = 1'b1;
               end
            end
         end
         READ: begin
            // Sub-word stores reuse the read as the first half of a read-modify-write.
            if (store_q) begin
               state_d     = WRITE;
               rw_d        = 1'b0;
               mem_wdata_d = merge_store(w_data_out_32, wdata_q, size_q);
            end else begin
               state_d      = DONE;
               en_d         = 1'b0;
               rw_d         = 1'b1;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_extend(w_data_out_32, size_q, uns_q);
            end
         end
         WRITE: begin
            state_d      = DONE;
            en_d         = 1'b0;
            rw_d         = 1'b1;
            resp_valid_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            en_d    = 1'b0;
            rw_d    = 1'b1;
         end
      endcase
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         store_q      <= 1'b0;
         size_q       <= SZ_BYTE;
         uns_q        <= 1'b0;
         wdata_q      <= '0;
         addr_q       <= '0;
         mem_wdata_q  <= '0;
         en_q         <= 1'b0;
         rw_q         <= 1'b1;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         store_q      <= store_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         wdata_q      <= wdata_d;
         addr_q       <= addr_d;
         mem_wdata_q  <= mem_wdata_d;
         en_q         <= en_d;
         rw_q         <= rw_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign resp_valid   = resp_valid_q;
   assign resp_err     = resp_err_q;
   assign resp_rdata   = resp_rdata_q;
   assign w_addr_32    = addr_q;
   assign w_data_in_32 = mem_wdata_q;
   assign en           = en_q;
   assign rw           = rw_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory, byte-level reference model and per-cycle response checker.
module tb_mem_access_unit;

   localparam int unsigned DEPTH = 4095;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] w_addr_32;
   logic [31:0] w_data_in_32;
   logic [31:0] w_data_out_32;
   logic        rw;
   logic        en;

   mem_access_unit #(.MEM_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .w_addr_32(w_addr_32), .w_data_in_32(w_data_in_32),
      .w_data_out_32(w_data_out_32), .rw(rw), .en(en)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Attached memory: big-endian, combinational read, write on posedge when en && !rw.
   bit [7:0] mem [0:DEPTH];
   always_comb begin
      if (w_addr_32 <= DEPTH - 3)
         w_data_out_32 = {mem[w_addr_32], mem[w_addr_32 + 1], mem[w_addr_32 + 2], mem[w_addr_32 + 3]};
      else
         w_data_out_32 = 32'd0;
   end
   always @(posedge clock) begin
      if (en && !rw && w_addr_32 <= DEPTH - 3) begin
         mem[w_addr_32]     <= w_data_in_32[31:24];
         mem[w_addr_32 + 1] <= w_data_in_32[23:16];
         mem[w_addr_32 + 2] <= w_data_in_32[15:8];
         mem[w_addr_32 + 3] <= w_data_in_32[7:0];
      end
   end

   // Reference model state
   bit [7:0] ref_mem [0:DEPTH];
   typedef struct {
      int          due;
      bit          err;
      logic [31:0] rdata;
      int          en_cyc;
   } exp_t;
   exp_t q[$];

   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   int          en_cnt = 0;
   logic [31:0] last_rdata;
   logic        last_err;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic logic [31:0] model_load(input int unsigned a, input logic [1:0] sz, input bit uns);
      logic [31:0] w;
      w = {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
      if (sz == 2'd0) return uns ? {24'd0, w[31:24]} : {{24{w[31]}}, w[31:24]};
      if (sz == 2'd1) return uns ? {16'd0, w[31:16]} : {{16{w[31]}}, w[31:16]};
      return w;
   endfunction

   // Response checker, evaluated every cycle at the falling edge
   always @(negedge clock) begin
      if (mon_en) begin
         chk("req_ready", {31'd0, req_ready}, {31'd0, q.size() == 0});
         if (en) en_cnt++;
         if (!en) chk("rw_when_idle_mem", {31'd0, rw}, 32'd1);
         if (q.size() != 0 && q[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout got=no_response want=resp_valid_at_cycle_%0d", q[0].due);
            void'(q.pop_front());
            en_cnt = 0;
         end else if (q.size() != 0 && q[0].due == cyc) begin
            chk("resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
            chk("resp_rdata", resp_rdata, q[0].rdata);
            chk("en_cycles", en_cnt, q[0].en_cyc);
            last_rdata = resp_rdata;
            last_err   = resp_err;
            void'(q.pop_front());
            en_cnt = 0;
         end else begin
            chk("resp_valid_quiet", {31'd0, resp_valid}, 32'd0);
            chk("resp_rdata_quiet", resp_rdata, 32'd0);
            if (q.size() == 0) chk("en_quiet", {31'd0, en}, 32'd0);
         end
      end
   end

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clock);
         #2;
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got=%0d_pending want=0", q.size());
         q.delete();
      end
   endtask

   task automatic do_req(input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd);
      exp_t e;
      bit   err;
      int   n = 0;
      int unsigned a;
      @(negedge clock);
      while (!req_ready && n < 10) begin
         @(negedge clock);
         n++;
      end
      req_valid    = 1'b1;
      req_store    = st;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      a   = addr;
      err = (sz == 2'd3) || (longint'(addr) + 3 > longint'(DEPTH));
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      if ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00)) err = 1'b1;
`endif
      e.err   = err;
      e.rdata = 32'd0;
      if (err) begin
         e.due    = cyc;
         e.en_cyc = 0;
      end else if (!st) begin
         e.due    = cyc + 1;
         e.en_cyc = 1;
         e.rdata  = model_load(a, sz, uns);
      end else begin
         if (sz == 2'd2) begin
            ref_mem[a] = wd[31:24]; ref_mem[a + 1] = wd[23:16];
            ref_mem[a + 2] = wd[15:8]; ref_mem[a + 3] = wd[7:0];
            e.due = cyc + 1; e.en_cyc = 1;
         end else if (sz == 2'd1) begin
            ref_mem[a] = wd[15:8]; ref_mem[a + 1] = wd[7:0];
            e.due = cyc + 2; e.en_cyc = 2;
         end else begin
            ref_mem[a] = wd[7:0];
            e.due = cyc + 2; e.en_cyc = 2;
         end
      end
      q.push_back(e);
      drain();
   endtask

   initial begin
      int diffs;
      logic [1:0] sz;
      logic [31:0] addr;
      int r;
      reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      @(posedge clock);
      @(negedge clock);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_en", {31'd0, en}, 32'd0);
      chk("rst_rw", {31'd0, rw}, 32'd1);
      chk("rst_w_addr", w_addr_32, 32'd0);
      chk("rst_w_data_in", w_data_in_32, 32'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      mon_en = 1'b1;

      do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678);
      do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      chk("word_roundtrip", last_rdata, 32'h12345678);

      do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'hAABBCCDD);
      do_req(1'b1, 2'd0, 1'b0, 32'h200, 32'h00000011);
      do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
      chk("byte_rmw", last_rdata, 32'h11BBCCDD);

      do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'h80FF0000);
      do_req(1'b0, 2'd0, 1'b0, 32'h300, 32'h0);
      chk("byte_signed", last_rdata, 32'hFFFFFF80);
      do_req(1'b0, 2'd1, 1'b1, 32'h300, 32'h0);
      chk("half_unsigned", last_rdata, 32'h000080FF);
      do_req(1'b1, 2'd1, 1'b0, 32'h300, 32'h0000BEEF);
      do_req(1'b0, 2'd1, 1'b0, 32'h300, 32'h0);
      chk("half_rmw_signed", last_rdata, 32'hFFFFBEEF);

      do_req(1'b0, 2'd2, 1'b0, DEPTH - 2, 32'h0);
      chk("range_err", {31'd0, last_err}, 32'd1);
      chk("range_err_rdata", last_rdata, 32'd0);
      do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
      chk("rsvd_size_err", {31'd0, last_err}, 32'd1);
      do_req(1'b0, 2'd0, 1'b0, DEPTH - 3, 32'h0);
      chk("last_valid_addr", {31'd0, last_err}, 32'd0);
      do_req(1'b0, 2'd0, 1'b0, 32'hFFFFFFFE, 32'h0);
      chk("no_wrap_err", {31'd0, last_err}, 32'd1);

      do_req(1'b1, 2'd0, 1'b0, 32'h104, 32'h0000009A);
      do_req(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      chk("misalign_trap", {31'd0, last_err}, 32'd1);
`else
      chk("misalign_pass", last_rdata, 32'h3456789A);
`endif

      // Reset while the unit sits in WRITE: the store must never reach memory.
      mon_en = 1'b0;
      @(negedge clock);
      req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h400; req_wdata = 32'hDEADBEEF;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      chk("write_state_en", {31'd0, en}, 32'd1);
      reset = 1'b1;
      #1;
      chk("reset_drops_en", {31'd0, en}, 32'd0);
      @(posedge clock);
      #1;
      chk("reset_no_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("post_reset_ready", {31'd0, req_ready}, 32'd1);
      chk("post_reset_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("aborted_store_mem", {mem[32'h400], mem[32'h401], mem[32'h402], mem[32'h403]}, 32'd0);
      mon_en = 1'b1;
      do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
      chk("aborted_store_load", last_rdata, 32'd0);

      for (int i = 0; i < 200; i++) begin
         r    = $urandom_range(0, 9);
         sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if (r == 0) addr = $urandom;
         else if (r == 1) addr = DEPTH - 4 + $urandom_range(0, 6);
         else addr = $urandom_range(32'h100, 32'h140);
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom);
      end

      diffs = 0;
      for (int i = 0; i <= DEPTH; i++)
         if (mem[i] != ref_mem[i]) diffs++;
      chk("final_memory_image", diffs, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
